// File: rtl/enemy_group_ctrl.sv
// enemy_group_ctrl
//   Per-frame sequencer for a group of N_ENEMIES single-enemy instances.
//   - Move generation: each channel gets a one-cycle strobe in index order.
//     Dead channels still take their slot, so the sequence always lasts
//     N_ENEMIES cycles.
//   - Drawing: live channels are enabled one at a time. Each channel is
//     followed by a one-cycle gap so its child can rearm. A watchdog ends
//     any channel that holds draw_en for TIMEOUT cycles without finishing.
//   - The active child's pixel stream is forwarded to one registered VGA
//     port with one cycle of latency.
//
// Ports
//   clock, reset        clock; asynchronous active-high reset
//   init                synchronous clear from the control FSM
//   gen_move, draw      level requests from the control FSM
//   alive               per-enemy alive mask (0 = skip)
//   child_*             flattened per-channel pixel stream and done flags
//   gen_move_en         one-hot move-generation strobe (masked by alive)
//   draw_en             one-hot (or zero) draw enable
//   gen_move_done       move generation finished, held while gen_move=1
//   x_draw, y_draw,
//   colour, VGA_write   registered pixel stream of the active channel
//   draw_done           all live enemies drawn, held while draw=1
//   active_idx          channel being generated or drawn (0 otherwise)
//   timeout_err         sticky watchdog flag, cleared by reset or init
module enemy_group_ctrl #(
    parameter int N_ENEMIES = 3,
    parameter int IDX_W     = 3,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int C_W       = 6,
    parameter int TIMEOUT   = 1023
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     init,
    input  logic                     gen_move,
    input  logic                     draw,
    input  logic [N_ENEMIES-1:0]     alive,
    input  logic [N_ENEMIES*X_W-1:0] child_x_draw,
    input  logic [N_ENEMIES*Y_W-1:0] child_y_draw,
    input  logic [N_ENEMIES*C_W-1:0] child_colour,
    input  logic [N_ENEMIES-1:0]     child_VGA_write,
    input  logic [N_ENEMIES-1:0]     child_draw_done,
    output logic [N_ENEMIES-1:0]     gen_move_en,
    output logic [N_ENEMIES-1:0]     draw_en,
    output logic                     gen_move_done,
    output logic [X_W-1:0]           x_draw,
    output logic [Y_W-1:0]           y_draw,
    output logic [C_W-1:0]           colour,
    output logic                     VGA_write,
    output logic                     draw_done,
    output logic [IDX_W-1:0]         active_idx,
    output logic                     timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, GEN, GEN_DONE, D_SEL, D_RUN, D_GAP, D_DONE
    } state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [WD_W-1:0]  wd, wd_nx;
    logic             terr_nx;
    logic             last_idx;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;

    logic [N_ENEMIES-1:0] idx_onehot;
    logic [X_W-1:0]       cur_x;
    logic [Y_W-1:0]       cur_y;
    logic [C_W-1:0]       cur_c;
    logic                 cur_wr;
    logic                 cur_done;

    assign last_idx = (idx == IDX_W'(N_ENEMIES - 1));

    // Lowest alive channel at or above idx. Scanning downward lets the
    // lowest match overwrite the others.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N_ENEMIES - 1; i >= 0; i--) begin
            if (alive[i] && (i >= int'(idx))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Channel mux for the current index.
    always_comb begin
        idx_onehot = '0;
        cur_x      = '0;
        cur_y      = '0;
        cur_c      = '0;
        cur_wr     = 1'b0;
        cur_done   = 1'b0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            if (idx == IDX_W'(i)) begin
                idx_onehot[i] = 1'b1;
                cur_x         = child_x_draw[i*X_W +: X_W];
                cur_y         = child_y_draw[i*Y_W +: Y_W];
                cur_c         = child_colour[i*C_W +: C_W];
                cur_wr        = child_VGA_write[i];
                cur_done      = child_draw_done[i];
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        wd_nx    = wd;
        terr_nx  = timeout_err;
        case (state)
            IDLE: begin
                if (gen_move) begin
                    state_nx = GEN;
                    idx_nx   = '0;
                end else if (draw) begin
                    state_nx = D_SEL;
                    idx_nx   = '0;
                end
            end
            GEN: begin
                if (last_idx) begin
                    state_nx = GEN_DONE;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            GEN_DONE: begin
                if (!gen_move) state_nx = IDLE;
            end
            D_SEL: begin
                if (!draw) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else if (sel_found) begin
                    state_nx = D_RUN;
                    idx_nx   = sel_idx;
                    wd_nx    = '0;
                end else begin
                    state_nx = D_DONE;
                    idx_nx   = '0;
                end
            end
            D_RUN: begin
                if (!draw) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else if (cur_done) begin
                    state_nx = D_GAP;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle of the channel.
                    state_nx = D_GAP;
                    terr_nx  = 1'b1;
                end else begin
                    wd_nx = wd + 1'b1;
                end
            end
            D_GAP: begin
                if (!draw) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else if (last_idx) begin
                    state_nx = D_DONE;
                    idx_nx   = '0;
                end else begin
                    state_nx = D_SEL;
                    idx_nx   = idx + 1'b1;
                end
            end
            D_DONE: begin
                if (!draw) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            wd          <= '0;
            timeout_err <= 1'b0;
            x_draw      <= '0;
            y_draw      <= '0;
            colour      <= '0;
            VGA_write   <= 1'b0;
        end else if (init) begin
            state       <= IDLE;
            idx         <= '0;
            wd          <= '0;
            timeout_err <= 1'b0;
            x_draw      <= '0;
            y_draw      <= '0;
            colour      <= '0;
            VGA_write   <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            wd          <= wd_nx;
            timeout_err <= terr_nx;
            // A pixel is forwarded only if we stay in D_RUN. Abort, timeout
            // and the child's done cycle all blank the port, which
            // guarantees a write-free cycle between channels. A child that
            // writes in its done cycle has that pixel dropped.
            if (state == D_RUN && state_nx == D_RUN) begin
                x_draw    <= cur_x;
                y_draw    <= cur_y;
                colour    <= cur_c;
                VGA_write <= cur_wr;
            end else begin
                x_draw    <= '0;
                y_draw    <= '0;
                colour    <= '0;
                VGA_write <= 1'b0;
            end
        end
    end

    assign gen_move_en   = (state == GEN)   ? (idx_onehot & alive) : '0;
    assign draw_en       = (state == D_RUN) ? idx_onehot : '0;
    assign gen_move_done = (state == GEN_DONE);
    assign draw_done     = (state == D_DONE);
    assign active_idx    = (state == GEN || state == D_RUN) ? idx : '0;

endmodule

// File: tb/tb_enemy_group_ctrl.sv
module tb_enemy_group_ctrl;
    localparam int N  = 3;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 6;
    localparam int IW = 3;
    localparam int TO = 1023;

    logic clock = 1'b0;
    logic reset, init, gen_move, draw;
    logic [N-1:0]    alive;
    logic [N*XW-1:0] cx;
    logic [N*YW-1:0] cy;
    logic [N*CW-1:0] cc;
    logic [N-1:0]    c_wr, c_done;
    logic [N-1:0]    gen_move_en, draw_en;
    logic            gen_move_done, VGA_write, draw_done, timeout_err;
    logic [XW-1:0]   x_draw;
    logic [YW-1:0]   y_draw;
    logic [CW-1:0]   colour;
    logic [IW-1:0]   active_idx;

    enemy_group_ctrl #(.N_ENEMIES(N), .IDX_W(IW), .X_W(XW), .Y_W(YW), .C_W(CW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .init(init), .gen_move(gen_move), .draw(draw),
        .alive(alive), .child_x_draw(cx), .child_y_draw(cy), .child_colour(cc),
        .child_VGA_write(c_wr), .child_draw_done(c_done),
        .gen_move_en(gen_move_en), .draw_en(draw_en), .gen_move_done(gen_move_done),
        .x_draw(x_draw), .y_draw(y_draw), .colour(colour), .VGA_write(VGA_write),
        .draw_done(draw_done), .active_idx(active_idx), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- child enemy models ----------------
    // While enabled, a child writes len[i] random pixels, then raises done
    // (unless hang[i]) until its enable drops.
    int            len  [N];
    bit            hang [N];
    int            cnt  [N];
    logic [XW-1:0] c_x  [N];
    logic [YW-1:0] c_y  [N];
    logic [CW-1:0] c_col[N];

    always @(posedge clock or posedge reset) begin
        for (int i = 0; i < N; i++) begin
            if (reset || !draw_en[i]) begin
                cnt[i] <= 0; c_wr[i] <= 1'b0; c_done[i] <= 1'b0;
                c_x[i] <= '0; c_y[i] <= '0; c_col[i] <= '0;
            end else if (cnt[i] < len[i]) begin
                c_wr[i]  <= 1'b1;
                c_x[i]   <= XW'($urandom);
                c_y[i]   <= YW'($urandom);
                c_col[i] <= CW'($urandom);
                cnt[i]   <= cnt[i] + 1;
            end else begin
                c_wr[i]   <= 1'b0;
                c_done[i] <= !hang[i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        assign cx[g*XW +: XW] = c_x[g];
        assign cy[g*YW +: YW] = c_y[g];
        assign cc[g*CW +: CW] = c_col[g];
    end

    // ---------------- monitor / scoreboard ----------------
    logic [XW+YW+CW-1:0] exp_q[$];
    int                  order_q[$];
    int                  en_len[N];
    int                  n_wr    = 0;
    int                  gap_err = 0;
    logic [N-1:0]        prev_en = '0;

    always @(posedge clock) begin
        if (VGA_write) begin
            n_wr++;
            if (exp_q.size() == 0) chk("pix_extra", 32'(VGA_write), 32'd0);
            else chk("pixel", 32'({x_draw, y_draw, colour}), 32'(exp_q.pop_front()));
        end
        if (!reset && draw)
            for (int i = 0; i < N; i++)
                if (c_wr[i] && draw_en[i]) exp_q.push_back({c_x[i], c_y[i], c_col[i]});
        for (int i = 0; i < N; i++) if (draw_en[i]) en_len[i]++;
        if (draw_en != '0 && prev_en == '0)
            for (int i = 0; i < N; i++) if (draw_en[i]) order_q.push_back(i);
        if ($countones(draw_en) > 1 || (draw_en != '0 && prev_en != '0 && draw_en != prev_en))
            gap_err++;
        prev_en = draw_en;
    end

    task automatic prep(input logic [N-1:0] a, input bit hang_ok);
        alive = a;
        for (int i = 0; i < N; i++) begin
            len[i]    = $urandom_range(1, 20);
            hang[i]   = hang_ok && ($urandom_range(0, 3) == 0);
            en_len[i] = 0;
        end
        order_q.delete();
        exp_q.delete();
        n_wr    = 0;
        gap_err = 0;
    endtask

    // Reference: live channels drawn in ascending order, every child pixel
    // forwarded once, hung channels held exactly TO cycles.
    task automatic wait_draw(input logic [N-1:0] a, input int budget);
        int   c = 0;
        int   k = 0;
        int   exp_wr = 0;
        logic any_hang = 1'b0;
        while (!draw_done && c < budget) begin tick(); c++; end
        chk("draw_done", 32'(draw_done), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (a[i]) begin
                exp_wr += len[i];
                if (hang[i]) begin
                    any_hang = 1'b1;
                    chk("wd_cycles", 32'(en_len[i]), 32'(TO));
                end
            end else begin
                chk("dead_skipped", 32'(en_len[i]), 32'd0);
            end
        end
        chk("n_order", 32'(order_q.size()), 32'($countones(a)));
        for (int i = 0; i < N; i++) begin
            if (a[i]) begin
                if (k < order_q.size()) chk("order", 32'(order_q[k]), 32'(i));
                k++;
            end
        end
        chk("n_wr", 32'(n_wr), 32'(exp_wr));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("gap", 32'(gap_err), 32'd0);
        chk("timeout_err", 32'(timeout_err), 32'(any_hang));
        chk("en_idle", 32'({draw_en, gen_move_en, VGA_write}), 32'd0);
        chk("mux_idle", 32'({x_draw, y_draw, colour}), 32'd0);
        draw = 1'b0;
        tick();
        chk("done_drop", 32'(draw_done), 32'd0);
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("init_clr", 32'(timeout_err), 32'd0);
    endtask

    task automatic run_gen(input int hold);
        logic [N-1:0] one = 1;
        logic [N-1:0] e;
        gen_move = 1'b1;
        for (int k = 0; k < N; k++) begin
            tick();
            e = alive & (one << k);
            chk("gen_en", 32'(gen_move_en), 32'(e));
            chk("gen_idx", 32'(active_idx), 32'(k));
            chk("gen_done_early", 32'(gen_move_done), 32'd0);
            chk("gen_no_draw", 32'(draw_en), 32'd0);
        end
        for (int h = 0; h <= hold; h++) begin
            tick();
            chk("gen_done", 32'(gen_move_done), 32'd1);
            chk("gen_en_off", 32'(gen_move_en), 32'd0);
        end
        gen_move = 1'b0;
        tick();
        chk("gen_done_drop", 32'(gen_move_done), 32'd0);
    endtask

    initial begin
        logic [N-1:0] a;
        reset = 1'b0; init = 1'b0; gen_move = 1'b0; draw = 1'b0; alive = '0;
        for (int i = 0; i < N; i++) begin len[i] = 1; hang[i] = 1'b0; end
        #1 reset = 1'b1;
        #2;
        chk("rst_gen_en", 32'(gen_move_en), 32'd0);
        chk("rst_draw_en", 32'(draw_en), 32'd0);
        chk("rst_gen_done", 32'(gen_move_done), 32'd0);
        chk("rst_draw_done", 32'(draw_done), 32'd0);
        chk("rst_pix", 32'({x_draw, y_draw, colour, VGA_write}), 32'd0);
        chk("rst_idx", 32'(active_idx), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // full alive gen sequence
        prep(3'b111, 1'b0);
        run_gen(2);

        // alive=101, 64 writes each
        prep(3'b101, 1'b0);
        len[0] = 64; len[2] = 64;
        draw = 1'b1;
        wait_draw(3'b101, 2000);

        // nothing alive
        prep(3'b000, 1'b0);
        draw = 1'b1;
        wait_draw(3'b000, 3);

        // channel 1 hangs
        prep(3'b111, 1'b0);
        hang[1] = 1'b1;
        draw = 1'b1;
        wait_draw(3'b111, 5000);

        // abort mid channel 0
        prep(3'b111, 1'b0);
        len[0] = 40;
        draw = 1'b1;
        repeat (10) tick();
        chk("abort_pre_en", 32'(draw_en), 32'd1);
        draw = 1'b0;
        chk("abort_hold_en", 32'(draw_en), 32'd1);
        tick();
        chk("abort_en", 32'(draw_en), 32'd0);
        chk("abort_wr", 32'(VGA_write), 32'd0);
        chk("abort_done", 32'(draw_done), 32'd0);
        chk("abort_idx", 32'(active_idx), 32'd0);
        tick();
        chk("abort_sb", 32'(exp_q.size()), 32'd0);
        prep(3'b111, 1'b0);
        draw = 1'b1;
        wait_draw(3'b111, 2000);

        // async reset mid-sequence
        prep(3'b111, 1'b0);
        len[0] = 40;
        draw = 1'b1;
        repeat (10) tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_en", 32'(draw_en), 32'd0);
        chk("arst_wr", 32'(VGA_write), 32'd0);
        chk("arst_done", 32'(draw_done), 32'd0);
        draw = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        prep(3'b111, 1'b0);
        draw = 1'b1;
        wait_draw(3'b111, 2000);

        // gen_move and draw raised together
        prep(3'b110, 1'b0);
        draw = 1'b1;
        run_gen(1);
        wait_draw(3'b110, 2000);

        // randomized frames
        for (int t = 0; t < 10; t++) begin
            a = N'($urandom_range(0, (1 << N) - 1));
            prep(a, (t % 3) == 0);
            run_gen($urandom_range(0, 3));
            draw = 1'b1;
            wait_draw(a, 5000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
